pixel_write_arbiter: RTL

// - Shares the single VGA adapter pixel port (x, y, colour, plot) between several drawing requesters.

---
 rtl/pixel_write_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin arbiter and filled-rectangle rasteriser
// sitting in front of the single vga_adapter pixel port.
// Optional feature: define PIXEL_ARB_CLIP_EN to suppress plot for pixels
// outside SCREEN_W x SCREEN_H (cycle count and done timing unchanged).
//
// Timing model: the acceptance edge already drives the first pixel onto
// x/y/colour/plot, and cx/cy track the pixel currently on the outputs.
// done is raised on the same edge that drives the last pixel, so it lines
// up with the last plot. No new command is accepted while done is high,
// which keeps done and ready in separate cycles.
module pixel_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int CW       = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*CW-1:0]  req_x,
  input  logic [NREQ*CW-1:0]  req_y,
  input  logic [NREQ*CW-1:0]  req_w,
  input  logic [NREQ*CW-1:0]  req_h,
  input  logic [NREQ*3-1:0]   req_colour,
  output logic [CW-1:0]       x,
  output logic [CW-1:0]       y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state, state_d;

  // per-requester command fields
  logic [NREQ-1:0][CW-1:0] xs, ys, ws, hs;
  logic [NREQ-1:0][2:0]    cs;

  assign xs = req_x;
  assign ys = req_y;
  assign ws = req_w;
  assign hs = req_h;
  assign cs = req_colour;

  // latched command and raster counters
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   x0, y0, w_q, h_q, cx, cy;
  logic [2:0]      col_q;

  // arbitration
  logic            found, accept, zero, single;
  logic [PW-1:0]   win, ptr_next;
  logic [NREQ-1:0] win_oh;
  int              idx;

  // raster stepping
  logic            row_end, last_next, pix_on;
  logic [CW-1:0]   ncx, ncy, bx, by, ox, oy;
  logic [CW:0]     sx, sy;

  // round-robin scan starting at ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign accept    = rst && (state == IDLE) && (done == '0) && found;
  assign win_oh    = NREQ'(1) << win;
  assign req_ready = accept ? win_oh : '0;
  assign ptr_next  = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
  assign zero      = (ws[win] == '0) || (hs[win] == '0);
  assign single    = (ws[win] == CW'(1)) && (hs[win] == CW'(1));
  assign busy      = (state == DRAW);

  // next raster position (row-major) and last-pixel lookahead
  always_comb begin
    row_end   = (cx == w_q - CW'(1));
    ncx       = row_end ? '0 : cx + CW'(1);
    ncy       = row_end ? cy + CW'(1) : cy;
    last_next = (ncx == w_q - CW'(1)) && (ncy == h_q - CW'(1));
    bx        = accept ? xs[win] : x0;
    by        = accept ? ys[win] : y0;
    ox        = accept ? '0 : ncx;
    oy        = accept ? '0 : ncy;
    sx        = {1'b0, bx} + {1'b0, ox};
    sy        = {1'b0, by} + {1'b0, oy};
  end

`ifdef PIXEL_ARB_CLIP_EN
  assign pix_on = (sx < (CW+1)'(SCREEN_W)) && (sy < (CW+1)'(SCREEN_H));
`else
  // coordinates wrap mod 2^CW; the carry bits are intentionally dropped
  logic carry_unused;
  assign carry_unused = sx[CW] ^ sy[CW];
  assign pix_on = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // next-state: zero-size and 1x1 commands complete without entering DRAW
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept && !zero && !single) state_d = DRAW;
      DRAW: if (last_next)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // command latch, raster counters and registered pixel outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      x0     <= '0;
      y0     <= '0;
      w_q    <= '0;
      h_q    <= '0;
      col_q  <= '0;
      cx     <= '0;
      cy     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      grant  <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      if (accept) begin
        ptr   <= ptr_next;
        x0    <= xs[win];
        y0    <= ys[win];
        w_q   <= ws[win];
        h_q   <= hs[win];
        col_q <= cs[win];
        cx    <= '0;
        cy    <= '0;
        if (zero) begin
          plot  <= 1'b0;
          grant <= '0;
          done  <= win_oh;
        end else begin
          x      <= sx[CW-1:0];
          y      <= sy[CW-1:0];
          colour <= cs[win];
          plot   <= pix_on;
          if (single) begin
            grant <= '0;
            done  <= win_oh;
          end else begin
            grant <= win_oh;
          end
        end
      end else if (state == DRAW) begin
        cx     <= ncx;
        cy     <= ncy;
        x      <= sx[CW-1:0];
        y      <= sy[CW-1:0];
        colour <= col_q;
        plot   <= pix_on;
        if (last_next) begin
          done  <= grant;
          grant <= '0;
        end
      end else begin
        plot  <= 1'b0;
        grant <= '0;
      end
    end
  end

endmodule
